// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared width default and branch-select encodings for the buffered demux
package mips_pkg;

   localparam int unsigned DEMUX_WIDTH = 32;

   typedef enum logic {
      BR0 = 1'b0,
      BR1 = 1'b1
   } br_sel_e;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/demux_fifo2.sv
// rtl/demux_fifo2.sv - two-entry in-order FIFO with registered head, one per demux branch
module demux_fifo2
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = DEMUX_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Self-protecting: a push to a full FIFO or a pop from an empty one is dropped.
   assign do_push = push && (count != FIFO_DEPTH);
   assign do_pop  = pop && (count != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Data storage is not reset; validity is carried by count alone.
   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/demux_32x2_buf.sv
// rtl/demux_32x2_buf.sv - 1-to-2 demux with a 2-entry FIFO per branch; DEMUX_STATS_EN adds per-branch accept counters
module demux_32x2_buf
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = DEMUX_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0]      stat0,
   output logic [15:0]      stat1
`endif
);

   logic [1:0] count0;
   logic [1:0] count1;
   logic       push0;
   logic       push1;
   logic       pop0;
   logic       pop1;
   logic       accept;

   // Ready looks only at the selected branch's occupancy, so a pop in the
   // same cycle never frees a slot for the incoming word.
   always_comb begin
      in_ready = 1'b0;
      if (in_sel == BR1) begin
         in_ready = (count1 < FIFO_DEPTH);
      end else begin
         in_ready = (count0 < FIFO_DEPTH);
      end
   end

   assign accept     = in_valid && in_ready;
   assign push0      = accept && (in_sel == BR0);
   assign push1      = accept && (in_sel == BR1);
   assign out0_valid = (count0 != 2'd0);
   assign out1_valid = (count1 != 2'd0);
   assign pop0       = out0_valid && out0_ready;
   assign pop1       = out1_valid && out1_ready;

   demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
      .clk   (clk),
      .reset (reset),
      .push  (push0),
      .pop   (pop0),
      .din   (in_data),
      .count (count0),
      .head  (out0_data)
   );

   demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
      .clk   (clk),
      .reset (reset),
      .push  (push1),
      .pop   (pop1),
      .din   (in_data),
      .count (count1),
      .head  (out1_data)
   );

`ifdef DEMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat0 <= 16'h0000;
         stat1 <= 16'h0000;
      end else begin
         if (push0 && (stat0 != 16'hFFFF)) begin
            stat0 <= stat0 + 16'h0001;
         end
         if (push1 && (stat1 != 16'hFFFF)) begin
            stat1 <= stat1 + 16'h0001;
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux_32x2_buf.sv
// tb/tb_demux_32x2_buf.sv - queue-scoreboard bench for the buffered 1-to-2 demux
module tb_demux_32x2_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_sel;
   logic [31:0] in_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out0_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
   logic [15:0] stat0;
   logic [15:0] stat1;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [15:0] exp_st0 = 16'h0;
   logic [15:0] exp_st1 = 16'h0;

   always #5 clk = ~clk;

   demux_32x2_buf #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
      ,
      .stat0      (stat0),
      .stat1      (stat1)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle, compare outputs against the queues, then advance the model.
   task automatic step(input logic rst, input logic v, input logic sel,
                       input logic [31:0] d, input logic r0, input logic r1);
      logic exp_rdy;
      logic acc;
      reset      = rst;
      in_valid   = v;
      in_sel     = sel;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      #1;
      exp_rdy = sel ? (q1.size() < 2) : (q0.size() < 2);
      check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      check("out0_valid", {63'b0, out0_valid}, {63'b0, q0.size() != 0});
      check("out1_valid", {63'b0, out1_valid}, {63'b0, q1.size() != 0});
      if (q0.size() != 0) check("out0_data", {32'b0, out0_data}, {32'b0, q0[0]});
      if (q1.size() != 0) check("out1_data", {32'b0, out1_data}, {32'b0, q1[0]});
      if (rst) begin
         q0.delete();
         q1.delete();
         exp_st0 = 16'h0;
         exp_st1 = 16'h0;
      end else begin
         acc = v && exp_rdy;
         if (r0 && q0.size() != 0) void'(q0.pop_front());
         if (r1 && q1.size() != 0) void'(q1.pop_front());
         if (acc) begin
            if (sel) begin
               q1.push_back(d);
               if (exp_st1 != 16'hFFFF) exp_st1 = exp_st1 + 16'h1;
            end else begin
               q0.push_back(d);
               if (exp_st0 != 16'hFFFF) exp_st0 = exp_st0 + 16'h1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_sel     = 1'b0;
      in_data    = 32'h0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset state, then a single word to branch 0.
      step(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      check("deadbeef_head", {32'b0, out0_data}, 64'hDEADBEEF);
      check("deadbeef_v1", {63'b0, out1_valid}, 64'h0);

      // Branch 1: third word refused, then ordered drain.
      step(1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
      check("b1_full_refuse", {63'b0, in_ready}, 64'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      check("b1_drained", {63'b0, out1_valid}, 64'h0);

      // Fill branch 0, then a stalled branch 0 must not block branch 1.
      step(1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
      check("a5_head", {32'b0, out1_data}, 64'hA5A5A5A5);

      // Full branch refuses even while popping.
      step(1'b0, 1'b1, 1'b0, 32'hBAD0BAD0, 1'b1, 1'b1);

      // Branch 0 at count 1: simultaneous push and pop.
      step(1'b0, 1'b1, 1'b0, 32'h7, 1'b1, 1'b0);
      check("pp_head7", {32'b0, out0_data}, 64'h7);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check("pp_count1", {62'b0, out0_valid, in_ready}, 64'h3);

      // Both full, reset with a push presented, then 0x55 emerges first.
      step(1'b0, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h9, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'hCC, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0);
      check("post_reset_55", {32'b0, out0_data}, 64'h55);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

`ifdef DEMUX_STATS_EN
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) begin
         step(1'b0, 1'b1, 1'b0, i[31:0], 1'b1, 1'b0);
      end
      check("stat0_sat", {48'b0, stat0}, {48'b0, exp_st0});
      check("stat0_ffff", {48'b0, stat0}, 64'hFFFF);
      check("stat1_zero", {48'b0, stat1}, {48'b0, exp_st1});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
